dcache_assoc: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate data cache. It is the next-generation replacement for the direct-mapped MEM-stage cache in the pipelined core.
- CPU side keeps the existing request/stall contract: combinational hit data and a `cpu_stall` that freezes the EX/MEM and MEM/WB registers.
- Memory side is a word-serial burst handshake to main memory.
- Adds configurable ways, sets and line size, LRU replacement, dirty write-back and optional hit/miss statistics.

---
 rtl/dcache_pkg.sv | 60 ++++++
 rtl/dcache_lru.sv | 50 +++++
 rtl/dcache_assoc.sv | 244 ++++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache: RV32I load/store size codes,
// the miss-handling FSM state type and the byte-lane helpers for loads and stores.
package dcache_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} cacheState_e;

   // Width of an index that selects one of n items; never narrower than one bit.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] loadExtend(input logic [31:0] word,
                                              input logic [1:0]  byteOff,
                                              input logic [2:0]  funct3);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      shifted = word >> {byteOff, 3'b000};
      b       = shifted[7:0];
      h       = byteOff[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   return {{24{b[7]}}, b};
         F3_LH:   return {{16{h[15]}}, h};
         F3_LW:   return word;
         F3_LBU:  return {24'h0, b};
         F3_LHU:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] storeMask(input logic [2:0] funct3,
                                            input logic [1:0] byteOff);
      case (funct3)
         F3_SB:   return 4'b0001 << byteOff;
         F3_SH:   return byteOff[1] ? 4'b1100 : 4'b0011;
         F3_SW:   return 4'b1111;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate right-aligned store data across lanes so the mask alone picks the bytes.
   function automatic logic [31:0] storeData(input logic [31:0] wdata,
                                             input logic [2:0]  funct3);
      case (funct3)
         F3_SB:   return {4{wdata[7:0]}};
         F3_SH:   return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU age tracking: ages form a permutation of 0..WAYS-1 in every set;
// the accessed way becomes 0 and the oldest way (age WAYS-1) is the victim.
module dcache_lru
   import dcache_pkg::*;
#(
   parameter  int WAYS  = 2,
   parameter  int SETS  = 64,
   localparam int WAY_W = idxWidth(WAYS),
   localparam int IDX_W = idxWidth(SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             updEn,
   input  logic [IDX_W-1:0] updIdx,
   input  logic [WAY_W-1:0] updWay,
   input  logic [IDX_W-1:0] vicIdx,
   output logic [WAY_W-1:0] vicWay
);

   logic [WAY_W-1:0] age [SETS][WAYS];

   // NOTE: non-blocking assignments in clocked blocks so every read in this edge sees
   // the pre-edge ages; a blocking update would leak the new age into later compares.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: unlike the data arrays, the age array is reset, because the
         // replacement order must start as a valid permutation in every set.
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age[s][w] <= WAY_W'(w);
      end else if (updEn) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == updWay)
               age[updIdx][w] <= '0;
            else if (age[updIdx][w] < age[updIdx][updWay])
               age[updIdx][w] <= age[updIdx][w] + WAY_W'(1);
         end
      end
   end

   // NOTE: every variable written in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      vicWay = '0;
      for (int w = 0; w < WAYS; w++)
         if (age[vicIdx][w] == WAY_W'(WAYS - 1))
            vicWay = WAY_W'(w);
   end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with word-serial
// refill/write-back bursts. Define DCACHE_STATS_EN to build the hit/miss counters.
module dcache_assoc
   import dcache_pkg::*;
#(
   parameter int WAYS       = 2,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_funct3,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int OFF_W  = $clog2(LINE_WORDS * 4);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = 32 - IDX_W - OFF_W;
   localparam int BEAT_W = OFF_W - 2;
   localparam int WAY_W  = idxWidth(WAYS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   logic [TAG_W-1:0]  tagArr   [WAYS][SETS];
   logic [31:0]       dataArr  [WAYS][SETS][LINE_WORDS];
   logic [WAYS-1:0]   validArr [SETS];
   logic [WAYS-1:0]   dirtyArr [SETS];

   logic [TAG_W-1:0]  reqTag;
   logic [IDX_W-1:0]  reqIdx;
   logic [BEAT_W-1:0] reqWord;
   logic [1:0]        reqByte;

   cacheState_e       state;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] beatNext;
   logic [WAY_W-1:0]  vicWay;

   logic [WAYS-1:0]   hitVec;
   logic [WAY_W-1:0]  hitWay;
   logic [WAY_W-1:0]  lruWay;
   logic [WAY_W-1:0]  freeWay;
   logic [WAY_W-1:0]  victimSel;
   logic              freeFound;
   logic              lookup;
   logic              hit;
   logic              miss;
   logic              refillBeat;
   logic              refillDone;
   logic [3:0]        wMask;
   logic [31:0]       wData;

   assign reqTag   = cpu_addr[31 -: TAG_W];
   assign reqIdx   = cpu_addr[OFF_W +: IDX_W];
   assign reqWord  = cpu_addr[2 +: BEAT_W];
   assign reqByte  = cpu_addr[1:0];
   assign beatNext = beat + BEAT_W'(1);

   always_comb begin
      hitVec = '0;
      hitWay = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (validArr[reqIdx][w] && (tagArr[w][reqIdx] == reqTag)) begin
            hitVec[w] = 1'b1;
            hitWay    = WAY_W'(w);
         end
      end
   end

   // Lowest invalid way wins; only a fully valid set falls back to the LRU choice.
   always_comb begin
      freeFound = 1'b0;
      freeWay   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!freeFound && !validArr[reqIdx][w]) begin
            freeFound = 1'b1;
            freeWay   = WAY_W'(w);
         end
      end
      victimSel = freeFound ? freeWay : lruWay;
   end

   // Outputs are gated by rst so the CPU side is quiet for the whole reset window.
   assign lookup     = rst && cpu_req && (state == IDLE);
   assign hit        = lookup && (|hitVec);
   assign miss       = lookup && !(|hitVec);
   assign cpu_stall  = rst && cpu_req && !hit;
   assign cpu_rdata  = (hit && !cpu_we)
                       ? loadExtend(dataArr[hitWay][reqIdx][reqWord], reqByte, cpu_funct3)
                       : '0;
   assign wMask      = storeMask(cpu_funct3, reqByte);
   assign wData      = storeData(cpu_wdata, cpu_funct3);
   assign refillBeat = (state == REFILL) && mem_ready;
   assign refillDone = refillBeat && (beat == LAST_BEAT);

   dcache_lru #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .clk    (clk),
      .rst    (rst),
      .updEn  (hit),
      .updIdx (reqIdx),
      .updWay (hitWay),
      .vicIdx (reqIdx),
      .vicWay (lruWay)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         beat      <= '0;
         vicWay    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  vicWay  <= victimSel;
                  beat    <= '0;
                  mem_req <= 1'b1;
                  if (validArr[reqIdx][victimSel] && dirtyArr[reqIdx][victimSel]) begin
                     state     <= WRITEBACK;
                     mem_we    <= 1'b1;
                     mem_addr  <= {tagArr[victimSel][reqIdx], reqIdx, {BEAT_W{1'b0}}, 2'b00};
                     mem_wdata <= dataArr[victimSel][reqIdx][0];
                  end else begin
                     state    <= REFILL;
                     mem_we   <= 1'b0;
                     mem_addr <= {reqTag, reqIdx, {BEAT_W{1'b0}}, 2'b00};
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  if (beat == LAST_BEAT) begin
                     state     <= REFILL;
                     beat      <= '0;
                     mem_we    <= 1'b0;
                     mem_addr  <= {reqTag, reqIdx, {BEAT_W{1'b0}}, 2'b00};
                     mem_wdata <= '0;
                  end else begin
                     beat      <= beatNext;
                     mem_addr  <= {tagArr[vicWay][reqIdx], reqIdx, beatNext, 2'b00};
                     mem_wdata <= dataArr[vicWay][reqIdx][beatNext];
                  end
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  if (beat == LAST_BEAT) begin
                     state    <= IDLE;
                     beat     <= '0;
                     mem_req  <= 1'b0;
                     mem_addr <= '0;
                  end else begin
                     beat     <= beatNext;
                     mem_addr <= {reqTag, reqIdx, beatNext, 2'b00};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            validArr[s] <= '0;
            dirtyArr[s] <= '0;
         end
      end else begin
         if (refillDone) begin
            validArr[reqIdx][vicWay] <= 1'b1;
            dirtyArr[reqIdx][vicWay] <= 1'b0;
         end
         if (hit && cpu_we)
            dirtyArr[reqIdx][hitWay] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; the valid bits alone make them meaningful.
   always_ff @(posedge clk) begin
      if (refillBeat) begin
         dataArr[vicWay][reqIdx][beat] <= mem_rdata;
         if (beat == LAST_BEAT)
            tagArr[vicWay][reqIdx] <= reqTag;
      end
      if (hit && cpu_we) begin
         for (int bl = 0; bl < 4; bl++)
            if (wMask[bl])
               dataArr[hitWay][reqIdx][reqWord][bl*8 +: 8] <= wData[bl*8 +: 8];
      end
   end

`ifdef DCACHE_STATS_EN
   logic        missPending;
   logic [31:0] hitCnt;
   logic [31:0] missCnt;

   // A missed request is counted once at detection; its eventual hit is not counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         missPending <= 1'b0;
         hitCnt      <= '0;
         missCnt     <= '0;
      end else begin
         if (miss) begin
            missPending <= 1'b1;
            if (missCnt != 32'hFFFF_FFFF)
               missCnt <= missCnt + 32'd1;
         end
         if (hit) begin
            missPending <= 1'b0;
            if (!missPending && (hitCnt != 32'hFFFF_FFFF))
               hitCnt <= hitCnt + 32'd1;
         end
      end
   end

   assign hit_count  = hitCnt;
   assign miss_count = missCnt;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (default 2-way, 64-set, 16-byte lines) with a
// word-serial memory responder and a log of every accepted memory beat.
module tb_dcache_assoc;
   import dcache_pkg::*;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [2:0]  cpu_funct3;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   beat_t       beats[$];
   logic [31:0] memModel [logic [31:0]];
   logic        readyEn;
   int          checks;
   int          failures;

   dcache_assoc dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_funct3 (cpu_funct3),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory side: decide readiness mid-cycle; a ready beat is taken at the next rising edge.
   always @(negedge clk) begin
      if (mem_req && readyEn) begin
         mem_ready = 1'b1;
         if (mem_we) begin
            memModel[mem_addr] = mem_wdata;
            mem_rdata = '0;
         end else begin
            mem_rdata = memModel.exists(mem_addr) ? memModel[mem_addr] : 32'hBAD0_BAD0;
         end
         beats.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
      end else begin
         mem_ready = 1'b0;
         mem_rdata = '0;
      end
   end

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rdata, output int stalls);
      logic done;
      @(posedge clk);
      #1;
      cpu_req    = 1'b1;
      cpu_we     = we;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      cpu_funct3 = f3;
      stalls     = 0;
      rdata      = '0;
      done       = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            rdata = cpu_rdata;
            done  = 1'b1;
         end else begin
            stalls++;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL access_timeout addr=%h: still stalled after %0d cycles", addr, stalls);
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      cpu_req    = 1'b1;
      cpu_we     = 1'b0;
      cpu_addr   = 32'h0001_0000;
      cpu_wdata  = '0;
      cpu_funct3 = F3_LW;
      #1 rst = 1'b0;
      #11;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
      checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata); end
      checks++; if ({hit_count, miss_count} !== 64'h0) begin failures++; $display("FAIL reset_counters got=%h/%h exp=0/0", hit_count, miss_count); end
      @(negedge clk);
      cpu_req = 1'b0;
      rst     = 1'b1;
   endtask

   task automatic test_cold_miss();
      logic [31:0] r;
      int          st;
      beats.delete();
      access(1'b0, 32'h0001_0000, 32'h0, F3_LW, r, st);
      checks++; if (r !== 32'h11) begin failures++; $display("FAIL cold_rdata got=%h exp=00000011", r); end
      checks++; if (st !== 5) begin failures++; $display("FAIL cold_stall_cycles got=%0d exp=5", st); end
      checks++;
      if (beats.size() !== 4) begin
         failures++; $display("FAIL cold_beat_count got=%0d exp=4", beats.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if ({beats[i].we, beats[i].addr} !== {1'b0, 32'h0001_0000 + 32'(4 * i)}) begin
               failures++;
               $display("FAIL cold_beat%0d got we=%b addr=%h exp we=0 addr=%h", i, beats[i].we, beats[i].addr, 32'h0001_0000 + 32'(4 * i));
            end
         end
      end
      access(1'b0, 32'h0001_0004, 32'h0, F3_LW, r, st);
      checks++; if (r !== 32'h22) begin failures++; $display("FAIL hit_word1 got=%h exp=00000022", r); end
      checks++; if (st !== 0) begin failures++; $display("FAIL hit_no_stall got=%0d exp=0", st); end
   endtask

   task automatic test_store_load();
      logic [31:0] r;
      int          st;
      access(1'b1, 32'h0001_0001, 32'h0000_0080, F3_SB, r, st);
      checks++; if (st !== 0) begin failures++; $display("FAIL sb_hit_stall got=%0d exp=0", st); end
      access(1'b0, 32'h0001_0001, 32'h0, F3_LB, r, st);
      checks++; if (r !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sign got=%h exp=ffffff80", r); end
      access(1'b0, 32'h0001_0001, 32'h0, F3_LBU, r, st);
      checks++; if (r !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zero got=%h exp=00000080", r); end
      access(1'b0, 32'h0001_0000, 32'h0, F3_LH, r, st);
      checks++; if (r !== 32'hFFFF_8011) begin failures++; $display("FAIL lh_sign got=%h exp=ffff8011", r); end
      access(1'b1, 32'h0001_0002, 32'hABCD_1234, F3_SH, r, st);
      checks++; if (st !== 0) begin failures++; $display("FAIL sh_hit_stall got=%0d exp=0", st); end
      access(1'b0, 32'h0001_0002, 32'h0, F3_LHU, r, st);
      checks++; if (r !== 32'h0000_1234) begin failures++; $display("FAIL lhu_upper got=%h exp=00001234", r); end
      access(1'b0, 32'h0001_0003, 32'h0, F3_LW, r, st);
      checks++; if (r !== 32'h1234_8011) begin failures++; $display("FAIL lw_misaligned got=%h exp=12348011", r); end
   endtask

   task automatic test_lru_clean();
      logic [31:0] r;
      int          st;
      int          writes;
      access(1'b0, 32'h0002_0000, 32'h0, F3_LW, r, st);
      checks++; if ({st, r} !== {32'd5, 32'hA0}) begin failures++; $display("FAIL fill_way1 got stall=%0d data=%h exp stall=5 data=000000a0", st, r); end
      access(1'b0, 32'h0001_0000, 32'h0, F3_LW, r, st);
      checks++; if ({st, r} !== {32'd0, 32'h1234_8011}) begin failures++; $display("FAIL reload_way0 got stall=%0d data=%h exp stall=0 data=12348011", st, r); end
      beats.delete();
      access(1'b0, 32'h0003_0000, 32'h0, F3_LW, r, st);
      checks++; if ({st, r} !== {32'd5, 32'hB0}) begin failures++; $display("FAIL evict_clean got stall=%0d data=%h exp stall=5 data=000000b0", st, r); end
      writes = 0;
      foreach (beats[i]) if (beats[i].we) writes++;
      checks++; if (writes !== 0) begin failures++; $display("FAIL evict_clean_writes got=%0d exp=0", writes); end
      checks++; if (beats.size() !== 4) begin failures++; $display("FAIL evict_clean_reads got=%0d exp=4", beats.size()); end
      access(1'b0, 32'h0001_0000, 32'h0, F3_LW, r, st);
      checks++; if (st !== 0) begin failures++; $display("FAIL lru_kept_way0 got stall=%0d exp=0", st); end
   endtask

   task automatic test_writeback();
      logic [31:0] r;
      int          st;
      logic [31:0] expWb [4];
      access(1'b1, 32'h0002_0000, 32'hDEAD_BEEF, F3_SW, r, st);
      checks++; if (st !== 5) begin failures++; $display("FAIL store_miss_stall got=%0d exp=5", st); end
      access(1'b0, 32'h0001_0000, 32'h0, F3_LW, r, st);
      beats.delete();
      access(1'b0, 32'h0003_0000, 32'h0, F3_LW, r, st);
      checks++; if ({st, r} !== {32'd9, 32'hB0}) begin failures++; $display("FAIL dirty_evict got stall=%0d data=%h exp stall=9 data=000000b0", st, r); end
      expWb = '{32'hDEAD_BEEF, 32'hA1, 32'hA2, 32'hA3};
      checks++;
      if (beats.size() !== 8) begin
         failures++; $display("FAIL wb_beat_count got=%0d exp=8", beats.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if ({beats[i].we, beats[i].addr, beats[i].data} !== {1'b1, 32'h0002_0000 + 32'(4 * i), expWb[i]}) begin
               failures++;
               $display("FAIL wb_beat%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h", i, beats[i].we, beats[i].addr, beats[i].data, 32'h0002_0000 + 32'(4 * i), expWb[i]);
            end
            checks++;
            if ({beats[i+4].we, beats[i+4].addr} !== {1'b0, 32'h0003_0000 + 32'(4 * i)}) begin
               failures++;
               $display("FAIL wb_refill%0d got we=%b addr=%h exp we=0 addr=%h", i, beats[i+4].we, beats[i+4].addr, 32'h0003_0000 + 32'(4 * i));
            end
         end
      end
      beats.delete();
      access(1'b0, 32'h0002_0000, 32'h0, F3_LW, r, st);
      checks++; if ({st, r} !== {32'd9, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wb_roundtrip got stall=%0d data=%h exp stall=9 data=deadbeef", st, r); end
      checks++;
      if (beats.size() < 1) begin
         failures++; $display("FAIL wb_way0_first got no beats exp write 00010000");
      end else if ({beats[0].we, beats[0].addr, beats[0].data} !== {1'b1, 32'h0001_0000, 32'h1234_8011}) begin
         failures++;
         $display("FAIL wb_way0_first got we=%b addr=%h data=%h exp we=1 addr=00010000 data=12348011", beats[0].we, beats[0].addr, beats[0].data);
      end
   endtask

   task automatic test_mem_stall();
      logic seen;
      logic done;
      logic [31:0] r;
      readyEn = 1'b0;
      beats.delete();
      @(posedge clk);
      #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0004_0010; cpu_funct3 = F3_LW;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (mem_req) seen = 1'b1;
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL stall_req_timeout got mem_req=%b exp=1", mem_req); end
      readyEn = 1'b1;
      @(posedge clk);
      #1;
      readyEn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({mem_req, mem_we, cpu_stall, mem_addr} !== {3'b101, 32'h0004_0014}) begin
            failures++;
            $display("FAIL stall_hold%0d got req=%b we=%b stall=%b addr=%h exp req=1 we=0 stall=1 addr=00040014", i, mem_req, mem_we, cpu_stall, mem_addr);
         end
      end
      readyEn = 1'b1;
      done = 1'b0;
      r = '0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            r = cpu_rdata;
            done = 1'b1;
         end
      end
      checks++; if ({done, r} !== {1'b1, 32'hC0}) begin failures++; $display("FAIL stall_resume got done=%b data=%h exp done=1 data=000000c0", done, r); end
      checks++; if (beats.size() !== 4) begin failures++; $display("FAIL stall_beat_count got=%0d exp=4", beats.size()); end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic seen;
      logic [31:0] r;
      int   st;
      readyEn = 1'b1;
      @(posedge clk);
      #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0005_0020; cpu_funct3 = F3_LW;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (mem_req) seen = 1'b1;
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rstmid_req_timeout got mem_req=%b exp=1", mem_req); end
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checks++; if ({mem_req, cpu_stall} !== 2'b00) begin failures++; $display("FAIL rstmid_drop got req=%b stall=%b exp req=0 stall=0", mem_req, cpu_stall); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", mem_addr); end
      checks++; if ({hit_count, miss_count} !== 64'h0) begin failures++; $display("FAIL rstmid_counters got=%h/%h exp=0/0", hit_count, miss_count); end
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      access(1'b0, 32'h0005_0020, 32'h0, F3_LW, r, st);
      checks++; if ({st, r} !== {32'd5, 32'hD0}) begin failures++; $display("FAIL rstmid_remiss got stall=%0d data=%h exp stall=5 data=000000d0", st, r); end
      access(1'b0, 32'h0001_0000, 32'h0, F3_LW, r, st);
      checks++; if ({st, r} !== {32'd5, 32'h1234_8011}) begin failures++; $display("FAIL rstmid_invalidated got stall=%0d data=%h exp stall=5 data=12348011", st, r); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      readyEn   = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         memModel[32'h0001_0000 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
         memModel[32'h0002_0000 + 32'(4 * i)] = 32'hA0 + 32'(i);
         memModel[32'h0003_0000 + 32'(4 * i)] = 32'hB0 + 32'(i);
         memModel[32'h0004_0010 + 32'(4 * i)] = 32'hC0 + 32'(i);
         memModel[32'h0005_0020 + 32'(4 * i)] = 32'hD0 + 32'(i);
      end
      test_reset();
      test_cold_miss();
      test_store_load();
      test_lru_clean();
      test_writeback();
      test_mem_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
